td4_program_loader: RTL

- Writable 16-word instruction store that replaces the fixed program ROM directly upstream of the TD4 CPU: drives the CPU's `instr` from the CPU's `address`, and owns the CPU's reset line.
- A host streams one byte per word over a valid/ready handshake while the CPU is held in reset. After the last word, the block releases the CPU, which then runs the new program from address 0.

---
 rtl/td4_program_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/td4_program_loader.sv
// td4_program_loader
// Writable 16-word instruction store sitting in place of the TD4 program ROM.
// A host streams one byte per word over a valid/ready handshake while the CPU
// is held in reset. Once the last word lands, the CPU is released after a
// short settling delay and runs the new program from address 0.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_HOLD    | CPU in reset, accepting host bytes into mem[ptr]
// ST_RELEASE | full program loaded, CPU still in reset while rel_cnt drains
// ST_RUN     | CPU released, store behaves as a read-only ROM
module td4_program_loader #(
  parameter int DEPTH          = 16,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load_start,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [3:0] address,
  output logic [7:0] instr,
  output logic       cpu_n_reset,
  output logic       loading,
  output logic       load_done
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // The counter is preloaded with one less than the hold time so that the
  // edge on which it is seen at zero is the edge that enters RUN.
  localparam logic [3:0] REL_INIT = 4'(RELEASE_CYCLES - 1);
  localparam logic [3:0] LAST_PTR = 4'(DEPTH - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] ptr;
  logic [3:0] ptr_nxt;
  logic [3:0] rel_cnt;
  logic [3:0] rel_cnt_nxt;
  logic       xfer;
  logic [7:0] mem [DEPTH];

  // load_start takes priority over a coincident byte so a restart never
  // writes a stray word.
  assign wr_ready = (state == ST_HOLD) & ~load_start;
  assign xfer     = wr_valid & wr_ready;

  // ROM-compatible read: no latency from address to instr.
  assign instr = mem[address];

  // Next-state, write pointer and release counter.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    rel_cnt_nxt = rel_cnt;
    case (state)
      ST_HOLD: begin
        if (load_start) begin
          ptr_nxt = '0;
        end else if (xfer) begin
          if (ptr == LAST_PTR) begin
            state_nxt   = ST_RELEASE;
            ptr_nxt     = '0;
            rel_cnt_nxt = REL_INIT;
          end else begin
            ptr_nxt = ptr + 4'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (load_start) begin
          state_nxt = ST_HOLD;
          ptr_nxt   = '0;
        end else if (rel_cnt == 4'd0) begin
          state_nxt = ST_RUN;
        end else begin
          rel_cnt_nxt = rel_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_nxt = ST_HOLD;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        ptr_nxt   = '0;
      end
    endcase
  end

  // FSM state plus registered CPU-facing outputs derived from the next state,
  // so every return to HOLD gives the CPU a clean falling reset edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_HOLD;
      ptr         <= '0;
      rel_cnt     <= '0;
      cpu_n_reset <= 1'b0;
      loading     <= 1'b1;
      load_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      rel_cnt     <= rel_cnt_nxt;
      cpu_n_reset <= (state_nxt == ST_RUN);
      loading     <= (state_nxt != ST_RUN);
      load_done   <= (state_nxt == ST_RUN) && (state != ST_RUN);
    end
  end

  // Instruction store: cleared on reset so a half-finished load never leaves
  // stale code behind, written one word per accepted byte.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (xfer) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule
